// File: rtl/key_encoder_pkg.sv
// key_encoder_pkg: shared FSM states, default debounce length and the 8-to-3 priority encoder.
package key_encoder_pkg;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Highest set bit wins; an all-zero input encodes as 0.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        prio_enc = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) prio_enc = 3'(i);
    endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync: two-flop synchronizer for raw asynchronous key lines.
module key_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o
);

    logic [W-1:0] meta_q, sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/key_encoder.sv
// key_encoder: debounced 8-key priority encoder with press strobe and held-valid.
// Define KEY_ENCODER_MULTI_ERR_EN to flag accepted presses with more than one key down on err.
module key_encoder
    import key_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key,
    output logic [2:0] code,
    output logic       valid,
    output logic       strobe,
    output logic       err
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    snap_q, ks;
    logic [2:0]    code_q;
    logic          valid_q, strobe_q, accept;

    key_sync #(.W(8)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(key),
        .sync_o (ks)
    );

    assign cnt_d  = cnt_q + CW'(1);
    // snap_q is never zero in DEBOUNCE, so a match implies a key is down.
    assign accept = (state_q == DEBOUNCE) && (ks == snap_q) && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            snap_q   <= '0;
            code_q   <= 3'd0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (ks != 8'd0) begin
                        snap_q  <= ks;
                        cnt_q   <= '0;
                        state_q <= DEBOUNCE;
                    end
                DEBOUNCE:
                    if (ks == 8'd0) state_q <= IDLE;
                    else if (ks != snap_q) begin
                        snap_q <= ks;
                        cnt_q  <= '0;
                    end else if (accept) begin
                        state_q  <= PRESSED;
                        code_q   <= prio_enc(snap_q);
                        valid_q  <= 1'b1;
                        strobe_q <= 1'b1;
                    end else cnt_q <= cnt_d;
                PRESSED:
                    if (ks == 8'd0) begin
                        cnt_q   <= '0;
                        state_q <= RELEASE;
                    end
                RELEASE:
                    if (ks != 8'd0) state_q <= PRESSED;
                    else if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else cnt_q <= cnt_d;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef KEY_ENCODER_MULTI_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else if (accept) err_q <= |(snap_q & (snap_q - 8'd1));
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign code   = code_q;
    assign valid  = valid_q;
    assign strobe = strobe_q;

endmodule

// File: tb/tb_key_encoder.sv
// tb_key_encoder: directed scenarios with a strobe-driven scoreboard, DEBOUNCE_CYCLES = 4.
module tb_key_encoder;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key = 8'd0;
    logic [2:0] code;
    logic       valid, strobe, err;

    int errors = 0;
    int checks = 0;
    int nstrobe = 0;
    logic strobe_prev = 1'b0;
    logic [3:0] exp_q[$];

    key_encoder #(.DEBOUNCE_CYCLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key),
        .code  (code),
        .valid (valid),
        .strobe(strobe),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] top_bit(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic multi(input logic [7:0] v);
`ifdef KEY_ENCODER_MULTI_ERR_EN
        return $countones(v) > 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic expect_press(input logic [7:0] v);
        exp_q.push_back({multi(v), top_bit(v)});
    endtask

    // Monitor: every strobe must match the oldest pending expected press.
    always @(negedge clk) begin
        if (rst_n && strobe) begin
            nstrobe++;
            if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
            else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                chk("sb_code", int'(code), int'(e[2:0]));
                chk("sb_err", int'(err), int'(e[3]));
                chk("sb_valid", int'(valid), 1);
            end
        end
        if (strobe && strobe_prev) chk("strobe_back_to_back", 1, 0);
        strobe_prev = strobe;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        step(3);
        chk("rst_code", int'(code), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_strobe", int'(strobe), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        step(3);

        // Scenario 1: latency of press and release
        key = 8'h08;
        expect_press(8'h08);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("s1_strobe", int'(strobe), int'(i == N + 3));
            chk("s1_valid", int'(valid), int'(i >= N + 3));
        end
        chk("s1_code", int'(code), 3);
        step(5);
        key = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("s1_rel_valid", int'(valid), int'(i < N + 3));
            chk("s1_rel_strobe", int'(strobe), 0);
        end
        chk("s1_code_retained", int'(code), 3);

        // Scenario 2: two keys, highest wins
        key = 8'h81;
        expect_press(8'h81);
        step(12);
        chk("s2_code", int'(code), 7);
        chk("s2_err", int'(err), int'(multi(8'h81)));
        chk("s2_valid", int'(valid), 1);
        key = 8'h00;
        step(12);
        chk("s2_err_held", int'(err), int'(multi(8'h81)));

        // Scenario 3: bouncing key never accepted until stable
        n0 = nstrobe;
        for (int i = 0; i < 5; i++) begin
            key = 8'h02;
            step(2);
            key = 8'h00;
            step(2);
        end
        chk("s3_no_strobe_bounce", nstrobe - n0, 0);
        key = 8'h02;
        expect_press(8'h02);
        step(12);
        chk("s3_one_strobe", nstrobe - n0, 1);
        chk("s3_code", int'(code), 1);

        // Scenario 4: release bounce while pressed
        n0 = nstrobe;
        key = 8'h00;
        step(2);
        key = 8'h02;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("s4_valid", int'(valid), 1);
        end
        chk("s4_no_restrobe", nstrobe - n0, 0);
        key = 8'h00;
        step(12);
        chk("s4_valid_fall", int'(valid), 0);

        // Scenario 5: reset mid-debounce with key held
        key = 8'h10;
        step(4);
        rst_n = 1'b0;
        step(1);
        chk("s5_code", int'(code), 0);
        chk("s5_valid", int'(valid), 0);
        chk("s5_strobe", int'(strobe), 0);
        chk("s5_err", int'(err), 0);
        rst_n = 1'b1;
        expect_press(8'h10);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("s5_strobe_after_rst", int'(strobe), int'(i == N + 3));
        end
        chk("s5_code_after", int'(code), 4);
        key = 8'h00;
        step(12);

        // Scenario 6: full sweep
        for (int v = 0; v < 256; v++) begin
            n0 = nstrobe;
            key = 8'(v);
            if (v != 0) expect_press(8'(v));
            step(20);
            chk("s6_strobes", nstrobe - n0, int'(v != 0));
            if (v != 0) chk("s6_code", int'(code), int'(top_bit(8'(v))));
            key = 8'h00;
            step(20);
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
